// File: rtl/smpl_core_mc.sv
// SMPL multi-cycle accumulator core: BOOT/FETCH/EXEC/DMEM/HALT sequencer with
// request/acknowledge instruction and data ports that tolerate wait states.
module smpl_core_mc #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          reset,
  output logic          ireq,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  input  logic          iack,
  output logic          dreq,
  output logic          dwe,
  output logic [AW-1:0] daddr,
  output logic [DW-1:0] dwdata,
  input  logic [DW-1:0] drdata,
  input  logic          dack,
  output logic [DW-1:0] acc,
  output logic          carry,
  output logic          halted
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_NOT = 4'h3,
    OP_LDA  = 4'h4, OP_STA = 4'h5, OP_JMP = 4'h6, OP_JZ  = 4'h7,
    OP_ADDI = 4'h8, OP_LDI = 4'h9, OP_OR  = 4'hA, OP_XOR = 4'hB,
    OP_SHL  = 4'hC, OP_SHR = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_EXEC, S_DMEM, S_HALT
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   pc_q;
  logic [DW-1:0]   ir_q;
  logic [DW-1:0]   acc_q;
  logic            carry_q;
  logic            ireq_q;
  logic            dreq_q;
  logic            dwe_q;
  logic [AW-1:0]   daddr_q;
  logic [DW-1:0]   dwdata_q;
  logic            halted_q;

  opcode_e         op;
  logic [AW-1:0]   operand;
  logic [DW-1:0]   imm;
  logic            mem_op;
  logic [DW-1:0]   src;
  logic [DW:0]     add_w;
  logic [DW:0]     sub_w;
  logic [DW-1:0]   acc_d;
  logic            carry_d;

  assign op      = opcode_e'(ir_q[DW-1 -: 4]);
  assign operand = ir_q[AW-1:0];
  assign imm     = {{(DW-AW){1'b0}}, operand};
  assign mem_op  = op inside {OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_LDA, OP_STA, OP_OR, OP_XOR};

  // Memory-class ops take their operand from the data port, the rest from the immediate.
  assign src   = mem_op ? drdata : imm;
  assign add_w = {1'b0, acc_q} + {1'b0, src};
  assign sub_w = {1'b0, acc_q} - {1'b0, src};

  // NOTE: every output of a combinational block gets a default first so that
  // no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    unique case (op)
      OP_ADD, OP_ADDI: begin acc_d = add_w[DW-1:0]; carry_d = add_w[DW]; end
      OP_SUB:          begin acc_d = sub_w[DW-1:0]; carry_d = sub_w[DW]; end
      OP_AND:          acc_d = acc_q & src;
      OP_OR:           acc_d = acc_q | src;
      OP_XOR:          acc_d = acc_q ^ src;
      OP_NOT:          acc_d = ~src;
      OP_LDA, OP_LDI:  acc_d = src;
      OP_SHL:          begin acc_d = {acc_q[DW-2:0], 1'b0}; carry_d = acc_q[DW-1]; end
      OP_SHR:          begin acc_d = {1'b0, acc_q[DW-1:1]}; carry_d = acc_q[0]; end
      default:         ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_BOOT;
      pc_q     <= '0;
      ir_q     <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      ireq_q   <= 1'b0;
      dreq_q   <= 1'b0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_BOOT: begin
          state_q <= S_FETCH;
          ireq_q  <= 1'b1;
        end
        S_FETCH: begin
          if (iack) begin
            ir_q    <= idata;
            pc_q    <= pc_q + AW'(1);
            ireq_q  <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (mem_op) begin
            dreq_q   <= 1'b1;
            daddr_q  <= operand;
            dwe_q    <= (op == OP_STA);
            dwdata_q <= acc_q;
            state_q  <= S_DMEM;
          end else if (op == OP_HLT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ireq_q  <= 1'b1;
            state_q <= S_FETCH;
            if ((op == OP_JMP) ||
                (op == OP_JZ && acc_q == '0) ||
                (op == OP_JC && carry_q))
              pc_q <= operand;
          end
        end
        S_DMEM: begin
          if (dack) begin
            if (op != OP_STA) begin
              acc_q   <= acc_d;
              carry_q <= carry_d;
            end
            dreq_q  <= 1'b0;
            dwe_q   <= 1'b0;
            ireq_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign ireq   = ireq_q;
  assign iaddr  = pc_q;
  assign dreq   = dreq_q;
  assign dwe    = dwe_q;
  assign daddr  = daddr_q;
  assign dwdata = dwdata_q;
  assign acc    = acc_q;
  assign carry  = carry_q;
  assign halted = halted_q;

endmodule

// File: doc/smpl_core_mc.md
# smpl_core_mc

Multi-cycle, parametrised accumulator CPU; next generation of the SMPL core. Fetches instructions and accesses data over two independent request/acknowledge memory ports, so it tolerates wait-state memories. Extends the instruction set to 16 opcodes with immediates, OR/XOR, shifts, a carry flag and halt. Sits between the instruction ROM and data RAM in the SMPL system.

## Interface
- DW, 16, data/accumulator width; legal range DW >= AW+4
- AW, 12, instruction/data address width; instruction word is DW bits: opcode = idata[DW-1:DW-4], operand = idata[AW-1:0]
- clock  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- ireq  out  1  instruction fetch request
- iaddr  out  AW  fetch address (= PC)
- idata  in  DW  instruction word, valid when iack=1
- iack  in  1  fetch acknowledge
- dreq  out  1  data request
- dwe  out  1  1 = write, 0 = read; valid while dreq=1
- daddr  out  AW  data address
- dwdata  out  DW  write data
- drdata  in  DW  read data, valid when dack=1
- dack  in  1  data acknowledge
- acc  out  DW  accumulator (observation)
- carry  out  1  carry flag
- halted  out  1  core stopped

## Operation
- State registers: pc (AW), ir (DW), acc (DW), carry, FSM state. Reset: state BOOT, pc=0, ir=0, acc=0, carry=0; all outputs 0.
- States: BOOT -> FETCH unconditionally. FETCH: ireq=1, iaddr=pc; stays until iack sampled 1, then ir<=idata, pc<=pc+1 (wraps 2^AW-1 -> 0), go EXEC. EXEC: memory-class ops go DMEM; all others execute and go FETCH; HLT goes HALT. DMEM: dreq=1, daddr=ir[AW-1:0], dwe=1 and dwdata=acc for STA; stays until dack=1, then applies result, go FETCH. HALT: halted=1, no requests; exit only by reset.
- Opcodes (M = memory word at operand, I = operand zero-extended to DW):
- 0 ADD: acc<=acc+M, carry<=carry-out. 1 SUB: acc<=acc-M, carry<=borrow (1 when acc<M unsigned). 2 AND, A OR, B XOR: acc<=acc op M, carry unchanged. 3 NOT: acc<=~M. 4 LDA: acc<=M. 5 STA: M<=acc.
- 6 JMP: pc<=operand. 7 JZ: pc<=operand if acc==0 (all bits). E JC: pc<=operand if carry=1.
- 8 ADDI: acc<=acc+I, carry<=carry-out. 9 LDI: acc<=I, carry unchanged.
- C SHL: acc<=acc<<1, carry<=old acc[DW-1]. D SHR logical: acc<=acc>>1, carry<=old acc[0]. F HLT.
- Ops not listed as affecting carry leave it unchanged. Unused operand bits ignored.

## Timing
- All outputs are registered-state decodes (Moore); no combinational path from iack/dack/idata/drdata to any output.
- Request rule: once ireq/dreq rises, it and its address/dwe/dwdata stay stable until the ack is sampled high at a rising edge; req drops the following cycle. Ack may be high in the first request cycle (zero wait). Acks while the matching request is low are ignored.
- ireq and dreq never high together.
- Zero-wait latency: non-memory op 2 cycles (FETCH, EXEC); memory op 3 cycles (FETCH, EXEC, DMEM). Each wait cycle adds one.
- acc/carry/pc updates visible the cycle after EXEC (register ops/jumps) or after the acked DMEM cycle.
- Reset mid-transaction: request drops immediately (async), transaction abandoned; first fetch from address 0 two cycles after reset release (BOOT, then FETCH).
- Taken jump to pc's own address allowed (tight loop); pc wrap needs no special handling.

## Test plan
- Zero-wait program LDI 5; ADDI 3; STA 0x010; HLT -> write of 8 to 0x010 with dwe=1, halted=1 after 9 cycles post-BOOT, acc=8, carry=0.
- DW=16: LDI 0xFFF, SHL x4 then ADDI 0x001 with acc=0xFFF0 -> acc=0xFFF1; then LDA of 0x0010 into ADD giving 0x10001 -> acc=0x0001, carry=1; JC 0x020 -> next iaddr=0x020.
- SUB 5 from acc=3 -> acc=0xFFFE, carry=1; JZ not taken; LDI 0; JZ 0x040 taken -> iaddr=0x040.
- Random 0-5 wait states on iack and dack -> ireq/dreq and addresses stable until ack, final memory image identical to zero-wait run.
- PC at 0xFFF (AW=12) executing LDI -> next iaddr=0x000.
- Assert reset during a held dreq of STA -> dreq, dwe fall immediately, acc=0, no write completes, fetch restarts at 0.
